// File: rtl/fpu_sched_if.sv
// Handshake bundle between the main FSM / FP units (master) and the FP execute scheduler (slave).
`timescale 1ns/1ps
interface fpu_sched_if;
  logic       ft_go;
  logic [4:0] funct5;
  logic       add_start;
  logic       mul_start;
  logic       div_start;
  logic       sqrt_start;
  logic       cvt_start;
  logic       div_done;
  logic       sqrt_done;
  logic [2:0] res_sel;
  logic       fregwrite_o;
  logic       xregwrite_o;
  logic       flpt_done;
  logic       busy;
  logic       err_illegal;
  logic       err_timeout;
  logic       err_overrun;

  modport master (
    output ft_go, funct5, div_done, sqrt_done,
    input  add_start, mul_start, div_start, sqrt_start, cvt_start,
    input  res_sel, fregwrite_o, xregwrite_o, flpt_done, busy,
    input  err_illegal, err_timeout, err_overrun
  );

  modport slave (
    input  ft_go, funct5, div_done, sqrt_done,
    output add_start, mul_start, div_start, sqrt_start, cvt_start,
    output res_sel, fregwrite_o, xregwrite_o, flpt_done, busy,
    output err_illegal, err_timeout, err_overrun
  );
endinterface

// File: rtl/fpu_sched.sv
// FP execute-phase sequencer: decodes funct5, pulses one unit start, waits on fixed
// latency or a done handshake, then issues the regfile write strobe and flpt_done.
`timescale 1ns/1ps
module fpu_sched #(
  parameter int LAT_ADD = 4,
  parameter int LAT_MUL = 3,
  parameter int LAT_CVT = 2,
  parameter int TIMEOUT = 255
) (
  input logic        clk,
  input logic        rstn,
  fpu_sched_if.slave fp
);

  localparam int MAX_L1  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
  localparam int MAX_L2  = (MAX_L1 > LAT_CVT) ? MAX_L1 : LAT_CVT;
  localparam int CNT_MAX = (TIMEOUT > MAX_L2) ? TIMEOUT : MAX_L2;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [2:0] SEL_ADD  = 3'd0;
  localparam logic [2:0] SEL_MUL  = 3'd1;
  localparam logic [2:0] SEL_DIV  = 3'd2;
  localparam logic [2:0] SEL_SQRT = 3'd3;
  localparam logic [2:0] SEL_CVT  = 3'd4;
  localparam logic [2:0] SEL_SGNJ = 3'd5;
  localparam logic [2:0] SEL_CMP  = 3'd6;
  localparam logic [2:0] SEL_MV   = 3'd7;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_FIX, S_WAIT_HS, S_WRITE} state_t;
  typedef enum logic [1:0] {K_FIX, K_HS, K_COMB} kind_t;

  state_t        state;
  kind_t         kind;
  logic          dest_fp;
  logic [CW-1:0] cnt;

  logic          dec_legal;
  kind_t         dec_kind;
  logic          dec_fp;
  logic [2:0]    dec_sel;
  logic [CW-1:0] fix_lat_m1;
  logic          hs_done;
  logic          to_write;
  logic          wr_ok;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    dec_legal = 1'b1;
    dec_kind  = K_COMB;
    dec_fp    = 1'b1;
    dec_sel   = SEL_ADD;
    case (fp.funct5)
      5'b00000, 5'b00001: begin dec_kind = K_FIX; dec_sel = SEL_ADD; end
      5'b00010:           begin dec_kind = K_FIX; dec_sel = SEL_MUL; end
      5'b00011:           begin dec_kind = K_HS;  dec_sel = SEL_DIV; end
      5'b01011:           begin dec_kind = K_HS;  dec_sel = SEL_SQRT; end
      5'b00100:           dec_sel = SEL_SGNJ;
      5'b00101:           dec_sel = SEL_CMP;
      5'b10100:           begin dec_sel = SEL_CMP; dec_fp = 1'b0; end
      5'b11000:           begin dec_kind = K_FIX; dec_sel = SEL_CVT; dec_fp = 1'b0; end
      5'b11010:           begin dec_kind = K_FIX; dec_sel = SEL_CVT; end
      5'b11100:           begin dec_sel = SEL_MV; dec_fp = 1'b0; end
      5'b11110:           dec_sel = SEL_MV;
      default:            dec_legal = 1'b0;
    endcase
  end

  // res_sel identifies the in-flight unit, so it also picks latency and done source.
  always_comb begin
    case (fp.res_sel)
      SEL_MUL: fix_lat_m1 = CW'(LAT_MUL - 1);
      SEL_CVT: fix_lat_m1 = CW'(LAT_CVT - 1);
      default: fix_lat_m1 = CW'(LAT_ADD - 1);
    endcase
  end

  assign hs_done = (fp.res_sel == SEL_SQRT) ? fp.sqrt_done : fp.div_done;

  always_comb begin
    to_write = 1'b0;
    wr_ok    = 1'b1;
    case (state)
      S_IDLE: begin
        to_write = fp.ft_go && !dec_legal;
        wr_ok    = 1'b0;
      end
      S_ISSUE:    to_write = (kind == K_COMB) || (kind == K_FIX && fix_lat_m1 == '0);
      S_WAIT_FIX: to_write = (cnt <= CW'(1));
      S_WAIT_HS: begin
        to_write = hs_done || (cnt <= CW'(1));
        wr_ok    = hs_done;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= S_IDLE;
      kind           <= K_COMB;
      dest_fp        <= 1'b0;
      cnt            <= '0;
      fp.add_start   <= 1'b0;
      fp.mul_start   <= 1'b0;
      fp.div_start   <= 1'b0;
      fp.sqrt_start  <= 1'b0;
      fp.cvt_start   <= 1'b0;
      fp.res_sel     <= SEL_ADD;
      fp.fregwrite_o <= 1'b0;
      fp.xregwrite_o <= 1'b0;
      fp.flpt_done   <= 1'b0;
      fp.busy        <= 1'b0;
      fp.err_illegal <= 1'b0;
      fp.err_timeout <= 1'b0;
      fp.err_overrun <= 1'b0;
    end else begin
      // Pulse outputs default low; the branches below raise them for exactly one cycle.
      fp.add_start   <= 1'b0;
      fp.mul_start   <= 1'b0;
      fp.div_start   <= 1'b0;
      fp.sqrt_start  <= 1'b0;
      fp.cvt_start   <= 1'b0;
      fp.fregwrite_o <= 1'b0;
      fp.xregwrite_o <= 1'b0;
      fp.flpt_done   <= 1'b0;

      if (fp.ft_go && state != S_IDLE) fp.err_overrun <= 1'b1;

      case (state)
        S_IDLE: begin
          if (fp.ft_go) begin
            fp.busy <= 1'b1;
            if (dec_legal) begin
              state         <= S_ISSUE;
              kind          <= dec_kind;
              dest_fp       <= dec_fp;
              fp.res_sel    <= dec_sel;
              fp.add_start  <= (dec_sel == SEL_ADD)  && (dec_kind == K_FIX);
              fp.mul_start  <= (dec_sel == SEL_MUL);
              fp.div_start  <= (dec_sel == SEL_DIV);
              fp.sqrt_start <= (dec_sel == SEL_SQRT);
              fp.cvt_start  <= (dec_sel == SEL_CVT);
            end else begin
              fp.err_illegal <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (kind == K_HS) begin
            cnt   <= CW'(TIMEOUT);
            state <= S_WAIT_HS;
          end else begin
            cnt   <= fix_lat_m1;
            state <= S_WAIT_FIX;
          end
        end
        S_WAIT_FIX: cnt <= cnt - 1'b1;
        S_WAIT_HS: begin
          cnt <= cnt - 1'b1;
          if (!hs_done && cnt <= CW'(1)) fp.err_timeout <= 1'b1;
        end
        S_WRITE: begin
          state   <= S_IDLE;
          fp.busy <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          fp.busy <= 1'b0;
        end
      endcase

      if (to_write) begin
        state          <= S_WRITE;
        fp.flpt_done   <= 1'b1;
        fp.fregwrite_o <= wr_ok && dest_fp;
        fp.xregwrite_o <= wr_ok && !dest_fp;
      end
    end
  end

endmodule

// File: tb/tb_fpu_sched.sv
// Self-checking bench for fpu_sched: directed cases plus randomized dispatches checked
// against a transaction-level model of latency, start pulse, write strobe and sticky errors.
`timescale 1ns/1ps
module tb_fpu_sched;
  localparam int LAT_ADD = 4;
  localparam int LAT_MUL = 3;
  localparam int LAT_CVT = 2;
  localparam int TIMEOUT = 255;
  localparam int MAXC    = 300;

  typedef enum {FIX, HS, COMB, ILL} okind_t;
  typedef struct {
    okind_t     kind;
    logic [2:0] sel;
    bit         fp;
    int         lat;
  } op_t;

  logic clk = 1'b0;
  logic rstn;
  fpu_sched_if bus ();

  fpu_sched #(.LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_CVT(LAT_CVT), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .fp   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  bit         exp_ill, exp_to, exp_ovr;
  logic [2:0] last_sel;
  bit         sel_known;

  logic [4:0] legal_ops [11] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b01011, 5'b00100,
                                 5'b00101, 5'b10100, 5'b11000, 5'b11010, 5'b11100};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] all_outs();
    return {bus.add_start, bus.mul_start, bus.div_start, bus.sqrt_start, bus.cvt_start,
            bus.res_sel, bus.fregwrite_o, bus.xregwrite_o, bus.flpt_done, bus.busy,
            bus.err_illegal, bus.err_timeout, bus.err_overrun};
  endfunction

  function automatic logic [4:0] start_vec();
    return {bus.add_start, bus.mul_start, bus.div_start, bus.sqrt_start, bus.cvt_start};
  endfunction

  // Opcode table: class, result-mux slot, destination file and fixed latency.
  function automatic op_t ref_decode(input logic [4:0] f);
    op_t o;
    o = '{kind: ILL, sel: 3'd0, fp: 1'b1, lat: 0};
    case (f)
      5'b00000, 5'b00001: o = '{kind: FIX,  sel: 3'd0, fp: 1'b1, lat: LAT_ADD};
      5'b00010:           o = '{kind: FIX,  sel: 3'd1, fp: 1'b1, lat: LAT_MUL};
      5'b00011:           o = '{kind: HS,   sel: 3'd2, fp: 1'b1, lat: 0};
      5'b01011:           o = '{kind: HS,   sel: 3'd3, fp: 1'b1, lat: 0};
      5'b00100:           o = '{kind: COMB, sel: 3'd5, fp: 1'b1, lat: 0};
      5'b00101:           o = '{kind: COMB, sel: 3'd6, fp: 1'b1, lat: 0};
      5'b10100:           o = '{kind: COMB, sel: 3'd6, fp: 1'b0, lat: 0};
      5'b11000:           o = '{kind: FIX,  sel: 3'd4, fp: 1'b0, lat: LAT_CVT};
      5'b11010:           o = '{kind: FIX,  sel: 3'd4, fp: 1'b1, lat: LAT_CVT};
      5'b11100:           o = '{kind: COMB, sel: 3'd7, fp: 1'b0, lat: 0};
      5'b11110:           o = '{kind: COMB, sel: 3'd7, fp: 1'b1, lat: 0};
      default:            ;
    endcase
    return o;
  endfunction

  task automatic model_reset();
    exp_ill   = 1'b0;
    exp_to    = 1'b0;
    exp_ovr   = 1'b0;
    last_sel  = 3'd0;
    sel_known = 1'b1;
  endtask

  // ft_go in cycle 0; hs_at = cycle the selected unit's done is high (0: never),
  // stray_at = cycle the other iterative unit's done is high, ovr_at = cycle of a second ft_go.
  task automatic run_op(input logic [4:0] f, input int hs_at, input int stray_at, input int ovr_at);
    op_t        op;
    int         exp_done;
    bit         exp_wr;
    logic [4:0] exp_start;
    int         done_c = -1;
    int         n_starts = 0;
    logic [4:0] start1 = '0;
    int         n_fw = 0;
    int         n_xw = 0;
    bit         wr_at_done = 1'b0;
    int         sel_bad = 0;
    int         busy_bad = 0;
    bit         sd, od;

    op = ref_decode(f);
    exp_wr = 1'b1;
    case (op.kind)
      ILL:  begin exp_done = 1; exp_wr = 1'b0; end
      COMB: exp_done = 2;
      FIX:  exp_done = 1 + op.lat;
      default: begin
        if (hs_at >= 2 && hs_at <= TIMEOUT + 1) exp_done = hs_at + 1;
        else begin exp_done = TIMEOUT + 2; exp_wr = 1'b0; end
      end
    endcase
    exp_start = (op.kind == FIX || op.kind == HS) ? (5'b10000 >> op.sel) : 5'b00000;

    @(negedge clk);
    check("gap_done", bus.flpt_done, 0);
    check("idle_busy", bus.busy, 0);
    if (sel_known) check("idle_sel_hold", bus.res_sel, last_sel);
    check("sticky_errs", {bus.err_illegal, bus.err_timeout, bus.err_overrun}, {exp_ill, exp_to, exp_ovr});
    bus.ft_go     = 1'b1;
    bus.funct5    = f;
    bus.div_done  = 1'b0;
    bus.sqrt_done = 1'b0;

    for (int c = 1; c <= MAXC && done_c < 0; c++) begin
      @(negedge clk);
      if (c == 1) start1 = start_vec();
      n_starts += $countones(start_vec());
      if (bus.fregwrite_o === 1'b1) n_fw++;
      if (bus.xregwrite_o === 1'b1) n_xw++;
      if (op.kind != ILL && bus.res_sel !== op.sel) sel_bad++;
      if (bus.busy !== 1'b1) busy_bad++;
      if (bus.flpt_done === 1'b1) begin
        done_c     = c;
        wr_at_done = bus.fregwrite_o | bus.xregwrite_o;
      end
      bus.ft_go  = (c == ovr_at);
      bus.funct5 = 5'($urandom());
      sd = (c == hs_at);
      od = (c == stray_at);
      if (op.sel == 3'd3) {bus.sqrt_done, bus.div_done} = {sd, od};
      else                {bus.div_done, bus.sqrt_done} = {sd, od};
    end

    check("done_cycle", done_c, exp_done);
    check("start_at_c1", start1, exp_start);
    check("start_count", n_starts, (exp_start != 0) ? 1 : 0);
    check("fwrite_count", n_fw, (exp_wr && op.fp) ? 1 : 0);
    check("xwrite_count", n_xw, (exp_wr && !op.fp) ? 1 : 0);
    check("write_at_done", wr_at_done, exp_wr);
    check("busy_held", busy_bad, 0);
    if (op.kind != ILL) check("res_sel_stable", sel_bad, 0);

    if (op.kind == ILL) exp_ill = 1'b1;
    if (op.kind == HS && !exp_wr) exp_to = 1'b1;
    if (ovr_at >= 1 && ovr_at <= exp_done) exp_ovr = 1'b1;
    if (op.kind == ILL) sel_known = 1'b0;
    else begin
      last_sel  = op.sel;
      sel_known = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] f;
    rstn          = 1'b0;
    bus.ft_go     = 1'b0;
    bus.funct5    = 5'b0;
    bus.div_done  = 1'b0;
    bus.sqrt_done = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_outs", all_outs(), 0);
    rstn = 1'b1;

    run_op(5'b00000, 0, 0, 0);   // fadd: start at 1, done at 5
    run_op(5'b10100, 0, 0, 0);   // fcmp: done at 2, integer write
    run_op(5'b00011, 20, 10, 0); // fdiv: done at 21, stray sqrt_done ignored
    run_op(5'b01011, 0, 30, 0);  // fsqrt never finishes: timeout at 257
    run_op(5'b11111, 0, 0, 1);   // illegal, second ft_go lands on WRITE

    foreach (legal_ops[i]) run_op(legal_ops[i], $urandom_range(2, 12), $urandom_range(1, 14), 0);
    run_op(5'b11110, 0, 0, 2);   // overrun exactly on the WRITE cycle of a comb op

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 8) f = legal_ops[$urandom_range(0, 10)];
      else                          f = 5'($urandom());
      run_op(f, $urandom_range(2, 40), $urandom_range(1, 45),
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0);
    end

    // Reset during a multiply aborts it with no write and no flpt_done.
    @(negedge clk);
    bus.ft_go     = 1'b1;
    bus.funct5    = 5'b00010;
    bus.div_done  = 1'b0;
    bus.sqrt_done = 1'b0;
    @(negedge clk);
    check("abort_mul_start", bus.mul_start, 1);
    bus.ft_go = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("abort_outs", all_outs(), 0);
    rstn = 1'b1;
    model_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("abort_quiet", {bus.flpt_done, bus.fregwrite_o, bus.xregwrite_o, bus.busy}, 0);
    end
    run_op(5'b00001, 0, 0, 0);

    @(negedge clk);
    check("final_gap_done", bus.flpt_done, 0);
    check("final_sticky", {bus.err_illegal, bus.err_timeout, bus.err_overrun}, {exp_ill, exp_to, exp_ovr});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
